tx_frame_assembler: RTL and testbench

- Transmit-side framer and the counterpart to the receive chain's synchronizer, symbol extraction and FFT path.
- Takes 64-sample time-domain data symbols from the IFFT and inserts the 16-sample cyclic prefix on each one.
- Prepends the 320-sample preamble (STF 160 + LTF 160) and emits a continuous PHASES-samples-per-clock stream to the DAC/framing path.
- Frame format on the wire matches the receiver exactly: 320 preamble samples followed by DATASYMBOLS x 80 samples.

---
 rtl/tx_frame_assembler.sv | 207 ++++++++++++++++++++
 tb/tb_tx_frame_assembler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_assembler.sv
// Transmit framer: preamble RAM beats followed by CP-expanded IFFT symbols, packed into PHASES-wide beats.
// Define TX_GUARD_EN to append GUARD_BEATS zero-valued valid beats after every frame.
module tx_frame_assembler #(
    parameter int DATAWIDTH   = 16,
    parameter int PHASES      = 64,
    parameter int FFTSIZE     = 64,
    parameter int CPLENGTH    = 16,
    parameter int DATASYMBOLS = 12,
    parameter int PREAMBLE    = 320,
    parameter int GUARD_BEATS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          pre_we_i,
    input  logic [8:0]                    pre_addr_i,
    input  logic [DATAWIDTH-1:0]          pre_re_i,
    input  logic [DATAWIDTH-1:0]          pre_im_i,
    input  logic [DATAWIDTH*FFTSIZE-1:0]  sym_re_i,
    input  logic [DATAWIDTH*FFTSIZE-1:0]  sym_im_i,
    input  logic                          sym_valid_i,
    output logic                          sym_ready_o,
    output logic [DATAWIDTH*PHASES-1:0]   re_o,
    output logic [DATAWIDTH*PHASES-1:0]   im_o,
    output logic                          valid_o,
    output logic                          sof_o,
    output logic                          eof_o,
    output logic                          busy_o,
    output logic                          underflow_o
);
    localparam int SYMLEN    = FFTSIZE + CPLENGTH;
    localparam int GBDEPTH   = SYMLEN + PHASES - 1;
    localparam int GBW       = GBDEPTH * DATAWIDTH;
    localparam int BW        = PHASES * DATAWIDTH;
    localparam int PRE_BEATS = PREAMBLE / PHASES;
    localparam int CW        = (PRE_BEATS > 1) ? $clog2(PRE_BEATS) : 1;
    localparam int LW        = $clog2(PHASES);
    localparam int FW        = $clog2(GBDEPTH + 1);
    localparam int AW        = $clog2(DATASYMBOLS + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GUARD} state_t;
    state_t state_q, state_n;

    logic [CW-1:0]            pre_cnt_q;
    logic [FW-1:0]            fill_q, fill_n;
    logic [AW-1:0]            acc_q, acc_n;
    logic [GBW-1:0]           gb_re_q, gb_im_q, gb_re_n, gb_im_n, cmb_re, cmb_im;
    logic [SYMLEN*DATAWIDTH-1:0] xp_re, xp_im;
    logic                     accept, emit, last;
    int                       combined;
    logic [BW-1:0]            re_n, im_n;
    logic                     valid_n, sof_n, eof_n;
    logic [BW-1:0]            pre_re_mem [PRE_BEATS];
    logic [BW-1:0]            pre_im_mem [PRE_BEATS];
    logic [CW-1:0]            wr_beat;
    logic [LW-1:0]            wr_lane;

`ifdef TX_GUARD_EN
    localparam int GW = $clog2(GUARD_BEATS + 1);
    logic [GW-1:0] guard_cnt_q;
`endif

    // Preamble stored beat-wide so a whole output beat reads in one cycle; contents survive reset.
    assign wr_beat = CW'(int'(pre_addr_i) / PHASES);
    assign wr_lane = LW'(int'(pre_addr_i) % PHASES);

    always_ff @(posedge clk_i) begin
        if (pre_we_i && !busy_o && (int'(pre_addr_i) < PREAMBLE)) begin
            pre_re_mem[wr_beat][wr_lane*DATAWIDTH +: DATAWIDTH] <= pre_re_i;
            pre_im_mem[wr_beat][wr_lane*DATAWIDTH +: DATAWIDTH] <= pre_im_i;
        end
    end

    // sym_valid_i/sym_ready_o: a symbol transfers on a clock edge where both are high;
    // sym_ready_o depends on registered state only, never on sym_valid_i.
    always_comb begin
        sym_ready_o = 1'b0;
        if (state_q == S_PRE)
            sym_ready_o = (int'(pre_cnt_q) == PRE_BEATS - 1);
        else if (state_q == S_DATA)
            sym_ready_o = (int'(fill_q) < PHASES) && (int'(acc_q) < DATASYMBOLS);
    end
    assign accept = sym_valid_i && sym_ready_o;

    always_comb begin
        xp_re = '0;
        xp_im = '0;
        for (int j = 0; j < SYMLEN; j++) begin
            if (j < CPLENGTH) begin
                xp_re[j*DATAWIDTH +: DATAWIDTH] = sym_re_i[(FFTSIZE-CPLENGTH+j)*DATAWIDTH +: DATAWIDTH];
                xp_im[j*DATAWIDTH +: DATAWIDTH] = sym_im_i[(FFTSIZE-CPLENGTH+j)*DATAWIDTH +: DATAWIDTH];
            end else begin
                xp_re[j*DATAWIDTH +: DATAWIDTH] = sym_re_i[(j-CPLENGTH)*DATAWIDTH +: DATAWIDTH];
                xp_im[j*DATAWIDTH +: DATAWIDTH] = sym_im_i[(j-CPLENGTH)*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Gearbox slots above fill_q are always zero, so appending is an OR at the fill offset.
    always_comb begin
        combined = int'(fill_q) + (accept ? SYMLEN : 0);
        cmb_re   = gb_re_q;
        cmb_im   = gb_im_q;
        if (accept) begin
            cmb_re = gb_re_q | (GBW'(xp_re) << (int'(fill_q) * DATAWIDTH));
            cmb_im = gb_im_q | (GBW'(xp_im) << (int'(fill_q) * DATAWIDTH));
        end
        emit    = (state_q == S_DATA) && (combined >= PHASES);
        gb_re_n = emit ? (cmb_re >> BW) : cmb_re;
        gb_im_n = emit ? (cmb_im >> BW) : cmb_im;
        fill_n  = emit ? FW'(combined - PHASES) : FW'(combined);
        acc_n   = accept ? acc_q + 1'b1 : acc_q;
        last    = emit && (int'(acc_n) == DATASYMBOLS) && (fill_n == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_n = S_PRE;
            S_PRE:   if (int'(pre_cnt_q) == PRE_BEATS - 1) state_n = S_DATA;
`ifdef TX_GUARD_EN
            S_DATA:  if (last) state_n = S_GUARD;
            S_GUARD: if (int'(guard_cnt_q) == GUARD_BEATS - 1) state_n = S_IDLE;
`else
            S_DATA:  if (last) state_n = S_IDLE;
            S_GUARD: state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        re_n    = '0;
        im_n    = '0;
        valid_n = 1'b0;
        sof_n   = 1'b0;
        eof_n   = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                re_n    = pre_re_mem[0];
                im_n    = pre_im_mem[0];
                valid_n = 1'b1;
                sof_n   = 1'b1;
            end
            S_PRE: begin
                re_n    = pre_re_mem[pre_cnt_q];
                im_n    = pre_im_mem[pre_cnt_q];
                valid_n = 1'b1;
            end
            S_DATA: if (emit) begin
                re_n    = cmb_re[BW-1:0];
                im_n    = cmb_im[BW-1:0];
                valid_n = 1'b1;
                eof_n   = last;
            end
            S_GUARD: valid_n = 1'b1;
            default: valid_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt_q   <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            gb_re_q     <= '0;
            gb_im_q     <= '0;
            re_o        <= '0;
            im_o        <= '0;
            valid_o     <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            busy_o      <= 1'b0;
            underflow_o <= 1'b0;
`ifdef TX_GUARD_EN
            guard_cnt_q <= '0;
`endif
        end else begin
            if (state_q == S_IDLE)
                pre_cnt_q <= start_i ? CW'(1) : '0;
            else if (state_q == S_PRE)
                pre_cnt_q <= (state_n == S_PRE) ? pre_cnt_q + 1'b1 : '0;
            fill_q  <= fill_n;
            acc_q   <= (state_q == S_IDLE) ? '0 : acc_n;
            gb_re_q <= gb_re_n;
            gb_im_q <= gb_im_n;
            re_o    <= re_n;
            im_o    <= im_n;
            valid_o <= valid_n;
            sof_o   <= sof_n;
            eof_o   <= eof_n;
            busy_o  <= (state_n != S_IDLE);
            if (state_q == S_IDLE && start_i)
                underflow_o <= 1'b0;
            else if (state_q == S_DATA && sym_ready_o && !sym_valid_i)
                underflow_o <= 1'b1;
`ifdef TX_GUARD_EN
            guard_cnt_q <= (state_q == S_GUARD) ? guard_cnt_q + 1'b1 : '0;
`endif
        end
    end
endmodule

// File: tb/tb_tx_frame_assembler.sv
// Directed bench for tx_frame_assembler: preamble, CP insertion, underflow, async abort, ignored requests.
// Build with TX_GUARD_EN defined to also exercise the guard interval.
module tb_tx_frame_assembler;
    localparam int DW = 16;
    localparam int PH = 64;
    localparam int NB = PH * DW;

    logic            clk_i, rst_i, start_i, pre_we_i, sym_valid_i, sym_ready_o;
    logic [8:0]      pre_addr_i;
    logic [DW-1:0]   pre_re_i, pre_im_i;
    logic [DW*64-1:0] sym_re_i, sym_im_i;
    logic [NB-1:0]   re_o, im_o;
    logic            valid_o, sof_o, eof_o, busy_o, underflow_o;

    tx_frame_assembler dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pre_we_i(pre_we_i),
        .pre_addr_i(pre_addr_i), .pre_re_i(pre_re_i), .pre_im_i(pre_im_i),
        .sym_re_i(sym_re_i), .sym_im_i(sym_im_i), .sym_valid_i(sym_valid_i),
        .sym_ready_o(sym_ready_o), .re_o(re_o), .im_o(im_o), .valid_o(valid_o),
        .sof_o(sof_o), .eof_o(eof_o), .busy_o(busy_o), .underflow_o(underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Expected wire stream: 320 preamble samples then 12 x (16 CP + 64) data samples.
    logic [DW-1:0] exp_re [0:1279];
    logic [DW-1:0] exp_im [0:1279];
    logic [NB-1:0] got_re_q[$];
    logic [NB-1:0] got_im_q[$];

    int sym_idx, gap_len, gaps_done;
    int n_sof, n_eof, sof_cyc, eof_cyc, n_gap;
    bit uf_seen, uf_first, busy_first;

    function automatic void build_model();
        for (int i = 0; i < 320; i++) begin
            exp_re[i] = DW'(i);
            exp_im[i] = DW'(-i);
        end
        for (int s = 0; s < 12; s++)
            for (int j = 0; j < 80; j++) begin
                exp_re[320 + s*80 + j] = DW'(256*s + ((j < 16) ? 48 + j : j - 16));
                exp_im[320 + s*80 + j] = '0;
            end
    endfunction

    function automatic logic [NB-1:0] model_re(input int b);
        logic [NB-1:0] v;
        for (int j = 0; j < PH; j++) v[j*DW +: DW] = exp_re[b*PH + j];
        return v;
    endfunction

    function automatic logic [NB-1:0] model_im(input int b);
        logic [NB-1:0] v;
        for (int j = 0; j < PH; j++) v[j*DW +: DW] = exp_im[b*PH + j];
        return v;
    endfunction

    function automatic logic [DW*64-1:0] sym_vec(input int s);
        logic [DW*64-1:0] v;
        for (int k = 0; k < 64; k++) v[k*DW +: DW] = DW'(256*s + k);
        return v;
    endfunction

    // Advance to the next negedge and drive the symbol source; symbol 4 is withheld for gap_len ready cycles.
    task automatic tick();
        @(negedge clk_i);
        if (sym_idx < 12) begin
            sym_re_i = sym_vec(sym_idx);
            sym_im_i = '0;
            if (sym_ready_o && sym_idx == 4 && gaps_done < gap_len) begin
                sym_valid_i = 1'b0;
                gaps_done++;
            end else begin
                sym_valid_i = 1'b1;
            end
            if (sym_valid_i && sym_ready_o) sym_idx++;
        end else begin
            sym_valid_i = 1'b0;
        end
    endtask

    task automatic load_preamble();
        for (int a = 0; a < 320; a++) begin
            pre_we_i = 1'b1; pre_addr_i = 9'(a);
            pre_re_i = DW'(a); pre_im_i = DW'(-a);
            tick();
        end
        pre_we_i = 1'b0;
    endtask

    // Pulse start and record one frame; returns one cycle after eof, or early at abort_cyc.
    task automatic run_frame(input int gap_l, input int inject_cyc, input int abort_cyc);
        bit done;
        got_re_q.delete(); got_im_q.delete();
        n_sof = 0; n_eof = 0; sof_cyc = -1; eof_cyc = -1; n_gap = 0;
        uf_seen = 0; done = 0;
        sym_idx = 0; gap_len = gap_l; gaps_done = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        uf_first = underflow_o;
        busy_first = busy_o;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc == abort_cyc) return;
            if (valid_o) begin
                got_re_q.push_back(re_o);
                got_im_q.push_back(im_o);
            end else begin
                n_gap++;
            end
            if (sof_o) begin n_sof++; sof_cyc = cyc; end
            if (eof_o) begin n_eof++; eof_cyc = cyc; done = 1; end
            if (underflow_o) uf_seen = 1;
            if (cyc == inject_cyc) begin
                start_i = 1'b1; pre_we_i = 1'b1; pre_addr_i = '0;
                pre_re_i = 16'h7777; pre_im_i = 16'h7777;
            end
            tick();
            start_i = 1'b0; pre_we_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (re_o !== '0 || im_o !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", re_o | im_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if ({sof_o, eof_o} !== 2'b00) begin failures++; $display("FAIL reset_sof_eof got=%b exp=00", {sof_o, eof_o}); end
        checks++; if ({sym_ready_o, busy_o, underflow_o} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {sym_ready_o, busy_o, underflow_o}); end
    endtask

    task automatic test_frame_basic();
        run_frame(0, -1, -1);
        checks++; if (got_re_q.size() !== 20) begin failures++; $display("FAIL basic_beats got=%0d exp=20", got_re_q.size()); end
        checks++; if (n_sof !== 1 || sof_cyc !== 0) begin failures++; $display("FAIL basic_sof got=%0d@%0d exp=1@0", n_sof, sof_cyc); end
        checks++; if (n_eof !== 1 || eof_cyc !== 19) begin failures++; $display("FAIL basic_eof got=%0d@%0d exp=1@19", n_eof, eof_cyc); end
        checks++; if (n_gap !== 0) begin failures++; $display("FAIL basic_gaps got=%0d exp=0", n_gap); end
        checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_first); end
        checks++; if (got_re_q[1][DW-1:0] !== 16'd64 || got_re_q[1][NB-1 -: DW] !== 16'd127) begin
            failures++; $display("FAIL basic_beat1 got=%0d..%0d exp=64..127", got_re_q[1][DW-1:0], got_re_q[1][NB-1 -: DW]);
        end
        for (int b = 0; b < got_re_q.size() && b < 20; b++) begin
            checks++;
            if (got_re_q[b] !== model_re(b) || got_im_q[b] !== model_im(b)) begin
                failures++; $display("FAIL basic_beat%0d got=%0h exp=%0h", b, got_re_q[b], model_re(b));
            end
        end
`ifndef TX_GUARD_EN
        checks++; if ({valid_o, busy_o, eof_o} !== 3'b000) begin failures++; $display("FAIL basic_idle got=%b exp=000", {valid_o, busy_o, eof_o}); end
        checks++; if (re_o !== '0) begin failures++; $display("FAIL basic_idle_data got=%0h exp=0", re_o); end
`endif
    endtask

    task automatic test_cp_insertion();
        logic [NB-1:0] e5, e6;
        for (int j = 0; j < PH; j++) begin
            e5[j*DW +: DW] = (j < 16) ? DW'(48 + j) : DW'(j - 16);
            e6[j*DW +: DW] = (j < 16) ? DW'(48 + j) : (j < 32) ? DW'(304 + j - 16) : DW'(256 + j - 32);
        end
        run_frame(0, -1, -1);
        checks++; if (got_re_q.size() !== 20) begin failures++; $display("FAIL cp_beats got=%0d exp=20", got_re_q.size()); end
        checks++; if (got_re_q[5] !== e5) begin failures++; $display("FAIL cp_beat5 got=%0h exp=%0h", got_re_q[5], e5); end
        checks++; if (got_re_q[6] !== e6) begin failures++; $display("FAIL cp_beat6 got=%0h exp=%0h", got_re_q[6], e6); end
        checks++; if (got_im_q[6] !== '0) begin failures++; $display("FAIL cp_beat6_im got=%0h exp=0", got_im_q[6]); end
    endtask

    task automatic test_underflow();
        run_frame(3, -1, -1);
        checks++; if (n_gap !== 3) begin failures++; $display("FAIL uf_gaps got=%0d exp=3", n_gap); end
        checks++; if (got_re_q.size() - 5 !== 15) begin failures++; $display("FAIL uf_data_beats got=%0d exp=15", got_re_q.size() - 5); end
        checks++; if (eof_cyc !== 22) begin failures++; $display("FAIL uf_eof got=%0d exp=22", eof_cyc); end
        checks++; if (uf_seen !== 1'b1 || underflow_o !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b%b exp=11", uf_seen, underflow_o); end
        for (int b = 0; b < got_re_q.size() && b < 20; b++) begin
            checks++;
            if (got_re_q[b] !== model_re(b) || got_im_q[b] !== model_im(b)) begin
                failures++; $display("FAIL uf_beat%0d got=%0h exp=%0h", b, got_re_q[b], model_re(b));
            end
        end
        tick(); tick();
        checks++; if (underflow_o !== 1'b1) begin failures++; $display("FAIL uf_hold got=%b exp=1", underflow_o); end
        run_frame(0, -1, -1);
        checks++; if (uf_first !== 1'b0 || uf_seen !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b%b exp=00", uf_first, uf_seen); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, -1, 10);
        checks++; if (valid_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b%b exp=11", valid_o, busy_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (re_o !== '0 || im_o !== '0) begin failures++; $display("FAIL abort_data got=%0h exp=0", re_o | im_o); end
        checks++; if ({valid_o, sof_o, eof_o, busy_o, sym_ready_o, underflow_o} !== 6'b0) begin
            failures++; $display("FAIL abort_ctrl got=%b exp=000000", {valid_o, sof_o, eof_o, busy_o, sym_ready_o, underflow_o});
        end
        tick(); tick();
        rst_i = 1'b0;
        tick();
        run_frame(0, -1, -1);
        checks++; if (got_re_q.size() !== 20 || eof_cyc !== 19) begin failures++; $display("FAIL abort_next got=%0d@%0d exp=20@19", got_re_q.size(), eof_cyc); end
        for (int b = 0; b < got_re_q.size() && b < 20; b++) begin
            checks++;
            if (got_re_q[b] !== model_re(b) || got_im_q[b] !== model_im(b)) begin
                failures++; $display("FAIL abort_beat%0d got=%0h exp=%0h", b, got_re_q[b], model_re(b));
            end
        end
    endtask

    task automatic test_ignore_busy();
        run_frame(0, 7, -1);
        checks++; if (n_sof !== 1) begin failures++; $display("FAIL busy_sof got=%0d exp=1", n_sof); end
        checks++; if (got_re_q.size() !== 20 || eof_cyc !== 19) begin failures++; $display("FAIL busy_frame got=%0d@%0d exp=20@19", got_re_q.size(), eof_cyc); end
        run_frame(0, -1, -1);
        checks++; if (got_re_q[0] !== model_re(0)) begin failures++; $display("FAIL busy_ram_re got=%0h exp=%0h", got_re_q[0], model_re(0)); end
        checks++; if (got_im_q[0] !== model_im(0)) begin failures++; $display("FAIL busy_ram_im got=%0h exp=%0h", got_im_q[0], model_im(0)); end
    endtask

`ifdef TX_GUARD_EN
    task automatic test_guard();
        run_frame(0, -1, -1);
        for (int g = 1; g <= 5; g++) begin
            checks++; if (valid_o !== (g <= 4)) begin failures++; $display("FAIL guard_valid%0d got=%b exp=%b", g, valid_o, g <= 4); end
            checks++; if (busy_o !== (g < 4)) begin failures++; $display("FAIL guard_busy%0d got=%b exp=%b", g, busy_o, g < 4); end
            checks++; if (re_o !== '0 || sof_o !== 1'b0) begin failures++; $display("FAIL guard_data%0d got=%0h exp=0", g, re_o); end
            start_i = (g == 2);
            tick();
            start_i = 1'b0;
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; pre_we_i = 1'b0; pre_addr_i = '0;
        pre_re_i = '0; pre_im_i = '0; sym_re_i = '0; sym_im_i = '0; sym_valid_i = 1'b0;
        sym_idx = 12; gap_len = 0; gaps_done = 0;
        build_model();
        tick(); tick();
        test_reset();
        rst_i = 1'b0;
        tick();
        load_preamble();
        tick();
        test_frame_basic();
`ifdef TX_GUARD_EN
        tick(); tick(); tick(); tick(); tick();
`endif
        test_cp_insertion();
`ifdef TX_GUARD_EN
        tick(); tick(); tick(); tick(); tick();
`endif
        test_underflow();
`ifdef TX_GUARD_EN
        tick(); tick(); tick(); tick(); tick();
`endif
        test_reset_mid_frame();
`ifdef TX_GUARD_EN
        tick(); tick(); tick(); tick(); tick();
`endif
        test_ignore_busy();
`ifdef TX_GUARD_EN
        tick(); tick(); tick(); tick(); tick();
        test_guard();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
